alu_sequencer: RTL



---
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute control unit that drives an external combinational ALU.
// Latency: data ops take FETCH+DECODE+EXECUTE (3 cycles min); JMP/RTN/NOP take FETCH+DECODE (2 cycles).
// Backpressure: FETCH holds instr_req until instr_ack; data memory is fixed one-cycle read latency.
module alu_sequencer #(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [ADDR_W+3:0] instr_rdata,
  output logic              dmem_rd_en,
  output logic              dmem_wr_en,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [SIZE-1:0]   dmem_wdata,
  input  logic [SIZE-1:0]   dmem_rdata,
  output logic              alu_ce,
  output logic [3:0]        alu_op_code,
  output logic [SIZE-1:0]   alu_left,
  output logic [SIZE-1:0]   alu_right,
  output logic              alu_carry_in,
  input  logic [SIZE-1:0]   alu_op_out,
  input  logic              alu_carry_out,
  output logic [SIZE-1:0]   acc,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_ADD       = 4'h0;
  localparam logic [3:0] OP_SUB       = 4'h1;
  localparam logic [3:0] OP_ST        = 4'h7;
  localparam logic [3:0] OP_LAST_DATA = 4'hB;
  localparam logic [3:0] OP_HLT       = 4'hC;
  localparam logic [3:0] OP_JMP       = 4'hD;
  localparam logic [3:0] OP_RTN       = 4'hE;
  localparam logic [3:0] OP_NOP       = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [3:0]        r_ir_op;
  logic [ADDR_W-1:0] r_ir_field;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ret;
  logic [SIZE-1:0]   r_acc;
  logic              r_carry;
  logic              r_zero;

  logic              w_fetch;
  logic              w_decode;
  logic              w_exec;
  logic              w_is_data;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_fetch   = (r_state == S_FETCH);
  assign w_decode  = (r_state == S_DECODE);
  assign w_exec    = (r_state == S_EXEC);
  assign w_is_data = (r_ir_op <= OP_LAST_DATA);
  assign w_pc_inc  = r_pc + PC_ONE;   // wraps modulo 2^ADDR_W

  // Sequencing: state, program counter and the single-level return register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ret   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
          end
        end
        S_FETCH: begin
          if (instr_ack) r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (r_ir_op)
            OP_HLT: r_state <= S_HALT;
            OP_JMP: begin
              r_ret   <= w_pc_inc;
              r_pc    <= r_ir_field;
              r_state <= S_FETCH;
            end
            OP_RTN: begin
              r_pc    <= r_ret;
              r_state <= S_FETCH;
            end
            OP_NOP: begin
              r_pc    <= w_pc_inc;
              r_state <= S_FETCH;
            end
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Instruction register: captured only on the acknowledged fetch cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir_op    <= '0;
      r_ir_field <= '0;
    end else if (w_fetch && instr_ack) begin
      r_ir_op    <= instr_rdata[ADDR_W+3:ADDR_W];
      r_ir_field <= instr_rdata[ADDR_W-1:0];
    end
  end

  // Accumulator and flags: written in EXECUTE by every data op except ST; only ADD/SUB touch carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_exec && (r_ir_op != OP_ST)) begin
      r_acc  <= alu_op_out;
      r_zero <= (alu_op_out == '0);
      if ((r_ir_op == OP_ADD) || (r_ir_op == OP_SUB)) r_carry <= alu_carry_out;
    end
  end

  // Strobes are decoded from state so they fall the instant rst clears the state register
  assign instr_req    = w_fetch;
  assign instr_addr   = r_pc;
  assign dmem_rd_en   = w_decode && w_is_data;
  assign dmem_wr_en   = w_exec && (r_ir_op == OP_ST);
  assign dmem_addr    = r_ir_field;
  assign dmem_wdata   = r_acc;
  assign alu_ce       = w_exec;
  assign alu_op_code  = r_ir_op;
  assign alu_left     = r_acc;
  assign alu_right    = dmem_rdata;
  assign alu_carry_in = r_carry;

  assign acc        = r_acc;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign pc         = r_pc;
  assign busy       = w_fetch || w_decode || w_exec;
  assign halted     = (r_state == S_HALT);

endmodule
